// File: rtl/sphere_pkg.sv
// Shared types, geometry helpers and width derivations for the sphere column generator.
package sphere_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam logic MODE_FILLED = 1'b0;
    localparam logic MODE_SHELL  = 1'b1;

    function automatic int center_x(input int num_cols);
        return num_cols / 2;
    endfunction

    function automatic int center_y(input int num_rows);
        return num_rows / 2;
    endfunction

    // Signed coordinate width: room for the larger axis plus sign plus an out-of-range column.
    function automatic int coord_width(input int num_cols, input int num_rows);
        return $clog2((num_cols > num_rows) ? num_cols : num_rows) + 2;
    endfunction

    function automatic int d2_width(input int coord_w);
        return 2 * coord_w;
    endfunction

    localparam int COORD_W = coord_width(64, 64);
    localparam int D2_W    = d2_width(COORD_W);

endpackage

// File: rtl/sphere_row_test.sv
// Combinational lit/unlit decision for one pixel of one channel column.
module sphere_row_test
    import sphere_pkg::*;
#(
    parameter int NUM_COLS = 64,
    parameter int NUM_ROWS = 64
) (
    input  logic [$clog2(NUM_COLS):0]   col_idx_in,
    input  logic [$clog2(NUM_ROWS)-1:0] y_in,
    input  logic [$clog2(NUM_ROWS):0]   radius_in,
    input  logic [$clog2(NUM_ROWS):0]   inner_in,
    input  logic                        mode_in,
    output logic                        lit_out
);

    localparam int CW = coord_width(NUM_COLS, NUM_ROWS);
    localparam int SW = d2_width(CW);
    localparam int CX = center_x(NUM_COLS);
    localparam int CY = center_y(NUM_ROWS);

    logic signed [SW-1:0] dx;
    logic signed [SW-1:0] dy;
    logic        [SW-1:0] d2;
    logic        [SW-1:0] r2;
    logic        [SW-1:0] i2;
    logic                 in_range;
    logic                 in_outer;
    logic                 out_inner;

    always_comb begin
        dx        = signed'(SW'(col_idx_in)) - signed'(SW'(CX));
        dy        = signed'(SW'(y_in)) - signed'(SW'(CY));
        d2        = unsigned'(dx * dx + dy * dy);
        r2        = SW'(radius_in) * SW'(radius_in);
        i2        = SW'(inner_in) * SW'(inner_in);
        in_range  = (SW'(col_idx_in) < SW'(NUM_COLS));
        in_outer  = (d2 <= r2);
        out_inner = (mode_in == MODE_FILLED) || (inner_in == '0) || (d2 > i2);
        lit_out   = in_range && in_outer && out_inner;
    end

endmodule

// File: rtl/sphere_column_gen.sv
// Renders NUM_CH sphere cross-section columns, one row per cycle, into a valid/ready output register.
module sphere_column_gen
    import sphere_pkg::*;
#(
    parameter int NUM_COLS = 64,
    parameter int NUM_ROWS = 64,
    parameter int NUM_CH   = 2,
    parameter int RGB_RES  = 9
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   req_valid_in,
    output logic                                   req_ready_out,
    input  logic [NUM_CH*($clog2(NUM_COLS)+1)-1:0] col_idx_in,
    input  logic [$clog2(NUM_ROWS):0]              radius_in,
    input  logic                                   mode_in,
    input  logic [$clog2(NUM_ROWS):0]              thickness_in,
    input  logic [RGB_RES-1:0]                     color_in,
    output logic [NUM_CH*NUM_ROWS*RGB_RES-1:0]     columns_out,
    output logic                                   columns_valid_out,
    input  logic                                   columns_ready_in,
    output logic                                   busy_out
);

    localparam int COL_W = $clog2(NUM_COLS) + 1;
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int RAD_W = $clog2(NUM_ROWS) + 1;

    typedef logic [NUM_CH-1:0][NUM_ROWS-1:0][RGB_RES-1:0] frame_t;

    state_t                         state_q,  state_d;
    logic   [ROW_W-1:0]             row_q,    row_d;
    logic   [NUM_CH-1:0][COL_W-1:0] col_q,    col_d;
    logic   [RAD_W-1:0]             radius_q, radius_d;
    logic   [RAD_W-1:0]             inner_q,  inner_d;
    logic                           mode_q,   mode_d;
    logic   [RGB_RES-1:0]           color_q,  color_d;
    frame_t                         work_q,   work_d;
    frame_t                         cols_q,   cols_d;
    logic                           valid_q,  valid_d;
    logic                           rdy_q,    rdy_d;
    logic                           busy_q,   busy_d;
    logic   [NUM_CH-1:0]            lit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sphere_row_test #(
            .NUM_COLS(NUM_COLS),
            .NUM_ROWS(NUM_ROWS)
        ) u_row_test (
            .col_idx_in(col_q[g]),
            .y_in      (row_q),
            .radius_in (radius_q),
            .inner_in  (inner_q),
            .mode_in   (mode_q),
            .lit_out   (lit[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        radius_d = radius_q;
        inner_d  = inner_q;
        mode_d   = mode_q;
        color_d  = color_q;
        work_d   = work_q;
        cols_d   = cols_q;
        valid_d  = valid_q;

        // Consumer handshake retires the current frame; XFER below may immediately reload it.
        if (valid_q && columns_ready_in) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid_in && rdy_q) begin
                    col_d    = col_idx_in;
                    radius_d = radius_in;
                    inner_d  = (radius_in > thickness_in) ? (radius_in - thickness_in) : '0;
                    mode_d   = mode_in;
                    color_d  = color_in;
                    work_d   = '0;
                    row_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    work_d[ch][row_q] = lit[ch] ? color_q : '0;
                end
                if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                    state_d = XFER;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            XFER: begin
                if (!valid_q || columns_ready_in) begin
                    cols_d  = work_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            radius_q <= '0;
            inner_q  <= '0;
            mode_q   <= MODE_FILLED;
            color_q  <= '0;
            work_q   <= '0;
            cols_q   <= '0;
            valid_q  <= 1'b0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            radius_q <= radius_d;
            inner_q  <= inner_d;
            mode_q   <= mode_d;
            color_q  <= color_d;
            work_q   <= work_d;
            cols_q   <= cols_d;
            valid_q  <= valid_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready_out     = rdy_q;
    assign busy_out          = busy_q;
    assign columns_out       = cols_q;
    assign columns_valid_out = valid_q;

endmodule

// File: tb/tb_sphere_column_gen.sv
// Self-checking bench: table of requests with a model-fed scoreboard, plus directed handshake/reset sequences.
module tb_sphere_column_gen;

    localparam int NUM_COLS = 64;
    localparam int NUM_ROWS = 64;
    localparam int NUM_CH   = 2;
    localparam int RGB_RES  = 9;
    localparam int COL_W    = $clog2(NUM_COLS) + 1;
    localparam int RAD_W    = $clog2(NUM_ROWS) + 1;
    localparam int FW       = NUM_CH * NUM_ROWS * RGB_RES;

    typedef logic [FW-1:0] frame_t;

    typedef struct {
        int col0;
        int col1;
        int radius;
        bit mode;
        int thick;
        int color;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic [NUM_CH*COL_W-1:0] col_idx = '0;
    logic [RAD_W-1:0]        radius = '0;
    logic                    mode = 1'b0;
    logic [RAD_W-1:0]        thickness = '0;
    logic [RGB_RES-1:0]      color = '0;
    frame_t                  columns;
    logic                    cvalid;
    logic                    cready = 1'b1;
    logic                    busy;

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t sb[$];

    always #5 clk = ~clk;

    sphere_column_gen #(
        .NUM_COLS(NUM_COLS),
        .NUM_ROWS(NUM_ROWS),
        .NUM_CH  (NUM_CH),
        .RGB_RES (RGB_RES)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .req_valid_in     (req_valid),
        .req_ready_out    (req_ready),
        .col_idx_in       (col_idx),
        .radius_in        (radius),
        .mode_in          (mode),
        .thickness_in     (thickness),
        .color_in         (color),
        .columns_out      (columns),
        .columns_valid_out(cvalid),
        .columns_ready_in (cready),
        .busy_out         (busy)
    );

    task automatic chk(input string name, input frame_t got, input frame_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference geometry in plain integers, straight from the disk/shell definition.
    function automatic frame_t model(input vec_t v);
        frame_t f = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int c = (ch == 0) ? v.col0 : v.col1;
            if (c < NUM_COLS) begin
                for (int y = 0; y < NUM_ROWS; y++) begin
                    int dx = c - NUM_COLS / 2;
                    int dy = y - NUM_ROWS / 2;
                    int d2 = dx * dx + dy * dy;
                    bit lit = (d2 <= v.radius * v.radius);
                    if (v.mode && v.thick < v.radius)
                        lit = lit && (d2 > (v.radius - v.thick) * (v.radius - v.thick));
                    if (lit) f[(ch * NUM_ROWS + y) * RGB_RES +: RGB_RES] = RGB_RES'(v.color);
                end
            end
        end
        return f;
    endfunction

    function automatic vec_t mk(input int c0, input int c1, input int r, input bit m,
                                input int t, input int col);
        vec_t v;
        v.col0 = c0; v.col1 = c1; v.radius = r; v.mode = m; v.thick = t; v.color = col;
        return v;
    endfunction

    function automatic frame_t const_frame(input int ch, input int lo, input int hi,
                                           input int col, input frame_t base);
        frame_t f = base;
        for (int y = lo; y <= hi; y++) f[(ch * NUM_ROWS + y) * RGB_RES +: RGB_RES] = RGB_RES'(col);
        return f;
    endfunction

    // Scoreboard: push on accepted request, pop on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (cvalid && cready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else chk("sb_frame", columns, sb.pop_front());
            end
            if (req_valid && req_ready)
                sb.push_back(model(mk(int'(col_idx[COL_W-1:0]), int'(col_idx[2*COL_W-1:COL_W]),
                                      int'(radius), mode, int'(thickness), int'(color))));
        end
    end

    task automatic do_req(input vec_t v);
        col_idx   = {COL_W'(v.col1), COL_W'(v.col0)};
        radius    = RAD_W'(v.radius);
        mode      = v.mode;
        thickness = RAD_W'(v.thick);
        color     = RGB_RES'(v.color);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        col_idx   = NUM_CH*COL_W'($urandom);
        radius    = RAD_W'($urandom);
        mode      = 1'($urandom);
        thickness = RAD_W'($urandom);
        color     = RGB_RES'($urandom);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!cvalid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!cvalid) chk("wait_valid_timeout", 0, 1);
    endtask

    vec_t   tbl[8];
    vec_t   v1, v2;
    frame_t snap, exp;
    int     lat;
    bit     ok;

    initial begin
        tbl[0] = mk(32, 0, 32, 0, 0, 'h1FF);
        tbl[1] = mk(32, 32, 10, 1, 4, 'h0A5);
        tbl[2] = mk(64, 20, 25, 0, 0, 'h155);
        tbl[3] = mk(31, 31, 0, 0, 0, 'h1FF);
        tbl[4] = mk(32, 32, 0, 1, 0, 'h0F0);
        tbl[5] = mk(40, 10, 12, 1, 12, 'h033);
        tbl[6] = mk(127, 45, 20, 1, 3, 'h1C7);
        tbl[7] = mk(0, 63, 31, 1, 30, 'h111);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", cvalid, 0);
        chk("rst_columns", columns, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);

        // Latency and handshake, with the filled radius-32 reference frame
        cready = 1'b1;
        do_req(tbl[0]);
        ok = 1; lat = 0;
        while (!cvalid && lat < 200) begin
            if (req_ready || !busy) ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, NUM_ROWS + 1);
        chk("req_ready_low_while_busy", ok, 1);
        chk("req_ready_after_xfer", req_ready, 1);
        exp = const_frame(0, 0, NUM_ROWS - 1, 'h1FF, '0);
        exp = const_frame(1, 32, 32, 'h1FF, exp);
        chk("filled_r32_frame", columns, exp);
        @(posedge clk); #1;
        chk("valid_clears_after_accept", cvalid, 0);

        // Shell reference frame: rows 22-25 and 39-42 on both channels
        do_req(tbl[1]);
        wait_valid(lat);
        exp = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp = const_frame(ch, 22, 25, 'h0A5, exp);
            exp = const_frame(ch, 39, 42, 'h0A5, exp);
        end
        chk("shell_r10_t4_frame", columns, exp);
        @(posedge clk); #1;

        // Table of requests, checked through the scoreboard
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i]);
            wait_valid(lat);
            @(posedge clk); #1;
        end
        chk("r0_col32_center_only", model(tbl[4]), const_frame(1, 32, 32, 'h0F0, const_frame(0, 32, 32, 'h0F0, '0)));

        // Backpressure: first frame held, second stalls in XFER
        cready = 1'b0;
        v1 = mk(32, 32, 5, 0, 0, 'h1AA);
        v2 = mk(32, 10, 20, 0, 0, 'h0FF);
        do_req(v1);
        wait_valid(lat);
        snap = columns;
        chk("bp_first_frame", snap, model(v1));
        do_req(v2);
        ok = 1;
        repeat (70) begin
            @(posedge clk); #1;
            if (!cvalid || columns !== snap) ok = 0;
        end
        chk("bp_output_stable", ok, 1);
        chk("bp_stall_req_ready", req_ready, 0);
        chk("bp_stall_busy", busy, 1);
        cready = 1'b1;
        @(posedge clk); #1;
        cready = 1'b0;
        chk("bp_reload_valid", cvalid, 1);
        chk("bp_reload_frame", columns, model(v2));
        chk("bp_reload_idle", req_ready, 1);
        cready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drain_valid", cvalid, 0);

        // Reset mid-CALC at row 30, then a fresh request
        do_req(tbl[5]);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", cvalid, 0);
        chk("midrst_columns", columns, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_busy", busy, 0);
        repeat (80) @(posedge clk);
        #1;
        chk("midrst_no_partial", cvalid, 0);
        do_req(tbl[6]);
        wait_valid(lat);
        chk("midrst_fresh_frame", columns, model(tbl[6]));
        @(posedge clk); #1;

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sphere_column_gen.md
Name: sphere_column_gen

Overview:
- Sequential, parametrised successor to the combinational sphere frame block for the rotating-panel volumetric display.
- Per request, renders NUM_CH panel columns of a sphere cross-section: filled disk or hollow shell, runtime radius and colour.
- Computes one row per cycle into a working buffer, then hands finished columns to the panel driver through a valid/ready output register.
- Sits between the angle/column scheduler and the HUB75 column shifter.

Parameters:
- NUM_COLS, 64, virtual columns per revolution slice; sets centre X = NUM_COLS/2.
- NUM_ROWS, 64, rows per column; sets centre Y = NUM_ROWS/2.
- NUM_CH, 2, columns rendered in parallel per request (panel halves).
- RGB_RES, 9, bits per pixel colour word.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- req_valid_in, input, 1, request strobe.
- req_ready_out, output, 1, high only in IDLE.
- col_idx_in, input, NUM_CH x $clog2(NUM_COLS)+1, column index per channel; values >= NUM_COLS render dark.
- radius_in, input, $clog2(NUM_ROWS)+1, sphere radius in pixels.
- mode_in, input, 1, 0 = filled, 1 = shell.
- thickness_in, input, $clog2(NUM_ROWS)+1, shell thickness (ignored when filled).
- color_in, input, RGB_RES, colour of lit pixels.
- columns_out, output, NUM_CH x NUM_ROWS x RGB_RES, finished columns.
- columns_valid_out, output, 1, columns_out holds a finished frame slice.
- columns_ready_in, input, 1, consumer accepts columns_out.
- busy_out, output, 1, state != IDLE.

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is synchronous, active-high.
- Reset: state = IDLE, row counter 0, working buffer and columns_out all zero, columns_valid_out 0, req_ready_out 1 on the first cycle after reset.
- Reset mid-operation: abandons any calculation and output; no partial frame is ever presented.
- States:
  - IDLE: on req_valid_in && req_ready_out, latch col_idx, radius, mode, thickness and colour; clear the working buffer; go to CALC, row = 0.
  - CALC: row y evaluated for all channels each cycle. After y = NUM_ROWS-1, go to XFER.
  - XFER: if !columns_valid_out, or columns_ready_in is high this cycle, copy the working buffer to columns_out, set columns_valid_out, go to IDLE. Otherwise hold in XFER.
- Output handshake:
  - columns_valid_out stays high and columns_out stays stable until columns_valid_out && columns_ready_in.
  - columns_valid_out then clears, unless XFER loads a new frame in the same cycle.
- Throughput: one request per NUM_ROWS+2 cycles under no backpressure.
- Latency: request accepted at edge 0 -> columns_valid_out high after edge NUM_ROWS+1.
- Arithmetic, per channel:
  - dx = col_idx - CENTER_X and dy = y - CENTER_Y, signed, $clog2(NUM_COLS|NUM_ROWS)+2 bits.
  - d2 = dx*dx + dy*dy, unsigned, wide enough for (max|d|)^2 * 2 with no overflow.
  - r2 = radius^2.
  - Filled mode: lit iff d2 <= r2.
  - Shell mode: inner = radius - thickness, saturating at 0; lit iff d2 <= r2 and (inner == 0 or d2 > inner^2).
  - Shell with thickness >= radius is identical to filled.
- Pixel value: lit -> latched colour, unlit -> 0.
- Boundaries:
  - radius 0 lights only the exact centre pixel, if a channel lands on CENTER_X.
  - Out-of-range column index -> whole column 0.
  - Input changes after acceptance have no effect.

Decomposition:
- Package sphere_pkg holds:
  - state enum (IDLE, CALC, XFER);
  - CENTER_X/CENTER_Y derivation functions;
  - width localparams: coordinate width, d2 width;
  - mode encoding constants.
- Sub-module sphere_row_test: combinational per-channel test (col_idx, y, radius, inner, mode -> lit). It is instantiated NUM_CH times inside the FSM block.

Test Plan:
- Defaults, filled, radius 32, col_idx {32,0}, colour 0x1FF -> ch0 all 64 rows = 0x1FF; ch1 only row 32 = 0x1FF, the rest 0.
- Shell, radius 10, thickness 4, col_idx {32,32} -> rows 22-25 and 39-42 lit, all others 0, both channels.
- Latency and handshake: columns_ready_in tied high, request at cycle 0 -> columns_valid_out rises after edge 65; req_ready_out low from cycle 1 to the XFER->IDLE edge.
- Backpressure:
  - Hold columns_ready_in low, issue two requests (radius 5 then radius 20). First output stays stable; second stalls in XFER with req_ready_out low.
  - Raise ready for one cycle -> radius-20 columns appear the next cycle with valid still high.
- Edge inputs: col_idx 64, or radius 0 at col 31 -> all-zero columns; radius 0 at col 32 -> only row 32 lit.
- Reset mid-CALC at row 30 -> next cycle columns_valid_out 0, columns_out 0, req_ready_out 1; a fresh request completes correctly.
